// File: rtl/act_share_arbiter_pkg.sv
// Shared definitions for the activation-unit share arbiter: FSM encoding and size defaults.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package act_share_arbiter_pkg;

  // Default configuration: four LSTM gate requesters sharing one 24-bit evaluator
  localparam int NREQ_DEF = 4;
  localparam int DW_DEF   = 24;

  // 3-bit FSM encodings
  localparam logic [2:0] ST_IDLE_ENC  = 3'd0;
  localparam logic [2:0] ST_ISSUE_ENC = 3'd1;
  localparam logic [2:0] ST_WAIT_ENC  = 3'd2;
  localparam logic [2:0] ST_RESP_ENC  = 3'd3;
  localparam logic [2:0] ST_GAP_ENC   = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE  = ST_IDLE_ENC,
    S_ISSUE = ST_ISSUE_ENC,
    S_WAIT  = ST_WAIT_ENC,
    S_RESP  = ST_RESP_ENC,
    S_GAP   = ST_GAP_ENC
  } state_t;

endpackage

// File: rtl/act_share_arbiter_rr_pick.sv
// Round-robin priority picker: first set req bit searching upward from ptr+1 with wrap.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the grant is consumed.
module act_share_arbiter_rr_pick
  import act_share_arbiter_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int IW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   gnt_idx,
  output logic            any
);

  logic [IW-1:0] cand;

  // Walk the candidates ptr+1 .. ptr+NREQ (mod NREQ); the last one checked is ptr itself
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    cand    = '0;
    for (int i = 1; i <= NREQ; i++) begin
      cand = IW'((int'(ptr) + i) % NREQ);
      if (!any && req[cand]) begin
        any       = 1'b1;
        gnt[cand] = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/act_share_arbiter.sv
// Round-robin sharing of one multi-cycle activation unit among NREQ requesters (optional ACT_SHARE_ARB_TIMEOUT_EN watchdog).
// Latency: handshake at cycle 0, act_in_valid rises cycle 1, rsp_valid one cycle after unit OUT_valid; GAP cycle before next grant.
// Backpressure: req_ready only asserted in IDLE for the round-robin winner; results are a one-cycle strobe with no stall.
module act_share_arbiter
  import act_share_arbiter_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int DW   = DW_DEF,
  parameter int IW   = 2,
  parameter int TMO  = 1023
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [DW-1:0]     rsp_data,
  output logic              rsp_err,
  output logic              act_in_valid,
  output logic [DW-1:0]     act_x,
  input  logic [DW-1:0]     act_out,
  input  logic              act_out_valid,
  output logic              busy
);

  state_t          state;
  state_t          state_nxt;
  logic [IW-1:0]   ptr;
  logic [IW-1:0]   owner;
  logic [DW-1:0]   x_q;
  logic [DW-1:0]   res_q;
  logic [NREQ-1:0] pick_gnt;
  logic [IW-1:0]   pick_idx;
  logic            pick_any;
  logic            hs;

`ifdef ACT_SHARE_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TMO + 1);
  logic [CW-1:0] tmo_cnt;
  logic          tmo_hit;
  logic          err_q;
`endif

  act_share_arbiter_rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .req     (req_valid),
    .ptr     (ptr),
    .gnt     (pick_gnt),
    .gnt_idx (pick_idx),
    .any     (pick_any)
  );

  // The grant is shown only in IDLE, so any asserted ready bit completes a handshake this cycle
  assign hs           = (state == S_IDLE) && pick_any;
  assign req_ready    = (state == S_IDLE) ? pick_gnt : '0;
  // Held high across ISSUE and WAIT so the unit sees exactly one rising edge per operand
  assign act_in_valid = (state == S_ISSUE) || (state == S_WAIT);
  assign act_x        = x_q;
  assign rsp_data     = res_q;
  assign busy         = (state != S_IDLE);

  // Next-state logic; act_out_valid matters only while waiting on the unit
  always_comb begin
    state_nxt = state;
`ifdef ACT_SHARE_ARB_TIMEOUT_EN
    tmo_hit   = 1'b0;
`endif
    case (state)
      S_IDLE:  if (pick_any) state_nxt = S_ISSUE;
      S_ISSUE: state_nxt = S_WAIT;
      S_WAIT: begin
        if (act_out_valid) begin
          state_nxt = S_RESP;
        end
`ifdef ACT_SHARE_ARB_TIMEOUT_EN
        else if (tmo_cnt == CW'(TMO)) begin
          state_nxt = S_RESP;
          tmo_hit   = 1'b1;
        end
`endif
      end
      S_RESP:  state_nxt = S_GAP;
      S_GAP:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // One-hot result strobe to the owner of the current transaction
  always_comb begin
    rsp_valid = '0;
    if (state == S_RESP) rsp_valid[owner] = 1'b1;
  end

  // State, round-robin pointer, operand/owner latch and result capture
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_IDLE;
      ptr   <= IW'(NREQ - 1);
      owner <= '0;
      x_q   <= '0;
      res_q <= '0;
    end else begin
      state <= state_nxt;
      if (hs) begin
        x_q   <= req_data[int'(pick_idx)*DW +: DW];
        owner <= pick_idx;
        ptr   <= pick_idx;
      end
      if (state == S_WAIT && act_out_valid) res_q <= act_out;
`ifdef ACT_SHARE_ARB_TIMEOUT_EN
      else if (tmo_hit) res_q <= '0;
`endif
    end
  end

`ifdef ACT_SHARE_ARB_TIMEOUT_EN
  // Watchdog: restarts at every grant, counts through ISSUE/WAIT; err flag tags the aborted result
  always_ff @(posedge clk) begin
    if (!rst) begin
      tmo_cnt <= '0;
      err_q   <= 1'b0;
    end else begin
      if (hs) tmo_cnt <= '0;
      else if (state == S_ISSUE || state == S_WAIT) tmo_cnt <= tmo_cnt + CW'(1);
      if (state == S_WAIT && act_out_valid) err_q <= 1'b0;
      else if (tmo_hit) err_q <= 1'b1;
    end
  end

  assign rsp_err = (state == S_RESP) && err_q;
`else
  assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_act_share_arbiter.sv
// Self-checking bench for act_share_arbiter with a behavioural activation-unit model.
// Latency: unit model answers LAT cycles after each act_in_valid rising edge.
// Backpressure: requesters hold req_valid until their grant handshake.
module tb_act_share_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 24;
  localparam int IW   = 2;
  localparam int TMO  = 15;
  localparam int LAT  = 10;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ-1:0]   rsp_valid;
  logic [DW-1:0]     rsp_data;
  logic              rsp_err;
  logic              act_in_valid;
  logic [DW-1:0]     act_x;
  logic [DW-1:0]     act_out;
  logic              act_out_valid;
  logic              busy;

  // unit model and injection
  logic          u_prev = 1'b0;
  logic          u_vld  = 1'b0;
  logic [DW-1:0] u_dat  = '0;
  logic [DW-1:0] u_x    = '0;
  int            u_cnt  = 0;
  logic          unit_mute;
  logic          inj_vld;
  logic [DW-1:0] inj_dat;

  typedef struct {
    logic [IW-1:0] owner;
    logic [DW-1:0] dat;
    logic          err;
    logic [DW-1:0] op;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [NREQ-1:0] mask;
    int              win;
    logic [DW-1:0]   base;
  } vec_t;
  vec_t vecs[12];

  int total = 0;
  int bad = 0;
  int hs_cnt = 0;
  int edge_cnt = 0;
  logic          prev_aiv = 1'b0;
  logic [DW-1:0] prev_x = '0;

  always #5 clk = ~clk;

  act_share_arbiter #(
    .NREQ (NREQ), .DW (DW), .IW (IW), .TMO (TMO)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_data      (req_data),
    .req_ready     (req_ready),
    .rsp_valid     (rsp_valid),
    .rsp_data      (rsp_data),
    .rsp_err       (rsp_err),
    .act_in_valid  (act_in_valid),
    .act_x         (act_x),
    .act_out       (act_out),
    .act_out_valid (act_out_valid),
    .busy          (busy)
  );

  function automatic logic [DW-1:0] f_act(input logic [DW-1:0] x);
    return {x[DW-2:0], x[DW-1]} ^ 24'h00F0F0;
  endfunction

  // Activation unit model: edge-triggered, one result pulse LAT cycles after the rising edge
  always @(posedge clk) begin
    u_prev <= act_in_valid;
    u_vld  <= 1'b0;
    if (act_in_valid && !u_prev && !unit_mute) begin
      u_cnt <= LAT - 1;
      u_x   <= act_x;
    end else if (u_cnt == 1) begin
      u_vld <= 1'b1;
      u_dat <= f_act(u_x);
      u_cnt <= 0;
    end else if (u_cnt != 0) begin
      u_cnt <= u_cnt - 1;
    end
  end

  assign act_out_valid = u_vld | inj_vld;
  assign act_out       = inj_vld ? inj_dat : u_dat;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic set_ops(input logic [DW-1:0] base);
    for (int k = 0; k < NREQ; k++) req_data[k*DW +: DW] = base ^ (DW'(k) << 20);
  endtask

  // Raise req_valid=mask, wait for the handshake, check the winner and push its expected result
  task automatic do_grant(input logic [NREQ-1:0] mask, input int win, input bit tmo, input string nm);
    exp_t e;
    bit hit = 1'b0;
    req_valid = mask;
    for (int n = 0; n < 300 && !hit; n++) begin
      #1;
      if ((req_valid & req_ready) != 0) begin
        hit = 1'b1;
        check(nm, 32'(req_ready), 32'(1) << win);
        e.owner = IW'(win);
        e.op    = req_data[win*DW +: DW];
        e.dat   = tmo ? '0 : f_act(e.op);
        e.err   = tmo;
        sb.push_back(e);
        hs_cnt++;
      end
      @(negedge clk);
    end
    if (!hit) begin
      total++;
      bad++;
      $display("FAIL %s: no grant within bound", nm);
    end
  endtask

  task automatic wait_drain(input string nm);
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL %s: %0d responses still outstanding", nm, sb.size());
    end
    repeat (3) @(negedge clk);
  endtask

  // Monitor: operand stability, scoreboard compare of every result strobe
  always @(negedge clk) begin
    if (act_in_valid && !prev_aiv) begin
      edge_cnt++;
      if (sb.size() > 0) check("act_x_at_edge", 32'(act_x), 32'(sb[$].op));
    end
    if (act_in_valid && prev_aiv) check("act_x_stable", 32'(act_x), 32'(prev_x));
    if (req_ready != 0) check("ready_rsp_overlap", 32'(rsp_valid), 32'd0);
    if (rsp_valid != 0) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_rsp: rsp_valid=%b rsp_data=%0h", rsp_valid, rsp_data);
      end else begin
        check("rsp_owner", 32'(rsp_valid), 32'(1) << sb[0].owner);
        check("rsp_data", 32'(rsp_data), 32'(sb[0].dat));
        check("rsp_err", 32'(rsp_err), 32'(sb[0].err));
        sb.delete(0);
      end
    end
    prev_aiv <= act_in_valid;
    prev_x   <= act_x;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{4'b1111, 3, 24'h010203};
    vecs[1]  = '{4'b1111, 0, 24'h0A0B0C};
    vecs[2]  = '{4'b1111, 1, 24'h123456};
    vecs[3]  = '{4'b0101, 2, 24'h0FFFFF};
    vecs[4]  = '{4'b0011, 0, 24'h800000};
    vecs[5]  = '{4'b1010, 1, 24'h7FFFFF};
    vecs[6]  = '{4'b1000, 3, 24'h000001};
    vecs[7]  = '{4'b0001, 0, 24'h0C0000};
    vecs[8]  = '{4'b0110, 1, 24'h055AA5};
    vecs[9]  = '{4'b0010, 1, 24'h002000};
    vecs[10] = '{4'b0010, 1, 24'h0FF000};
    vecs[11] = '{4'b1001, 3, 24'h0ABCDE};

    req_valid = '0;
    req_data  = '0;
    inj_vld   = 1'b0;
    inj_dat   = 24'h7FFFFF;
    unit_mute = 1'b0;
    rst       = 1'b0;
    repeat (3) @(negedge clk);

    // reset state
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_aiv", 32'(act_in_valid), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_data", 32'(rsp_data), 32'd0);
    check("rst_act_x", 32'(act_x), 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // single request from k=2, 1.0 in Q14, cycle-accurate timeline
    set_ops(24'h104000);
    req_data[2*DW +: DW] = 24'h004000;
    do_grant(4'b0100, 2, 1'b0, "t1_grant");
    req_valid = '0;
    for (int c = 1; c <= 14; c++) begin
      check("t1_aiv", 32'(act_in_valid), 32'(c <= 11));
      check("t1_rsp", 32'(rsp_valid), (c == 12) ? 32'h4 : 32'h0);
      check("t1_busy", 32'(busy), 32'(c <= 13));
      inj_vld = (c == 13);   // spurious result while in GAP
      @(negedge clk);
    end
    inj_vld = 1'b0;

    // spurious result while IDLE
    inj_vld = 1'b1;
    @(negedge clk);
    inj_vld = 1'b0;
    check("idle_spur_busy", 32'(busy), 32'd0);
    @(negedge clk);
    check("idle_spur_rsp", 32'(rsp_valid), 32'd0);
    check("idle_spur_busy2", 32'(busy), 32'd0);

    // table-driven arbitration vectors
    for (int i = 0; i < 12; i++) begin
      set_ops(vecs[i].base);
      do_grant(vecs[i].mask, vecs[i].win, 1'b0, $sformatf("vec%0d_grant", i));
      req_valid = '0;
    end
    wait_drain("vec_drain");

    // reset during WAIT, then a late unit result must be ignored
    set_ops(24'h033333);
    do_grant(4'b0100, 2, 1'b0, "rstw_grant");
    req_valid = '0;
    repeat (3) @(negedge clk);
    check("rstw_in_wait", 32'(act_in_valid), 32'd1);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    sb.delete();
    check("rstw_busy", 32'(busy), 32'd0);
    check("rstw_aiv", 32'(act_in_valid), 32'd0);
    check("rstw_act_x", 32'(act_x), 32'd0);
    check("rstw_rsp_data", 32'(rsp_data), 32'd0);
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      check("rstw_late_rsp", 32'(rsp_valid), 32'd0);
    end
    check("rstw_idle", 32'(busy), 32'd0);

    // all requesters held: order restarts at index 0
    set_ops(24'h044444);
    begin
      int order[5] = '{0, 1, 2, 3, 0};
      for (int g = 0; g < 5; g++) do_grant(4'b1111, order[g], 1'b0, $sformatf("rr_all%0d", g));
    end
    req_valid = '0;
    wait_drain("rr_drain");

`ifdef ACT_SHARE_ARB_TIMEOUT_EN
    // unit never answers: aborted result at cycle 17, then the next requester is served
    unit_mute = 1'b1;
    set_ops(24'h055555);
    do_grant(4'b0010, 1, 1'b1, "tmo_grant");
    req_valid = '0;
    for (int c = 1; c <= 18; c++) begin
      check("tmo_rsp", 32'(rsp_valid), (c == 17) ? 32'h2 : 32'h0);
      check("tmo_errline", 32'(rsp_err), 32'(c == 17));
      @(negedge clk);
    end
    unit_mute = 1'b0;
    set_ops(24'h066666);
    do_grant(4'b0110, 2, 1'b0, "tmo_next");
    req_valid = '0;
    wait_drain("tmo_drain");
`endif

    check("edges_vs_grants", 32'(edge_cnt), 32'(hs_cnt));
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
